reduce_tree_pipe: RTL

//  Parametrised, pipelined N-input bit-reduction unit; successor to the fixed 8-way AND gate.
//  - Reduces N input bits to 1 through a balanced binary tree, one register per tree level.
//  - Operation is selectable per beat.
//  - Uses valid/ready handshakes with bubble-collapsing backpressure.
//  - Sits between ALU flag logic and any consumer that needs wide AND/OR/XOR/NAND reductions.

---
 rtl/reduce_tree_pipe.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/reduce_tree_pipe.sv
// reduce_tree_pipe: pipelined N-input AND/OR/XOR/NAND bit reduction.
// The balanced binary tree has one register per level. Backpressure uses
// valid/ready, and an empty stage accepts data even while downstream stalls.
// Optional build macro REDUCE_ACCUM_EN folds multi-beat bursts into one result.
// Node storage is a flat heap: level k (1..L) occupies N>>k bits starting at
// offset N - (N>>(k-1)). The last node bit is the final tree value.
module reduce_tree_pipe #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic [1:0]   op,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out,
   output logic         out_last
);

   localparam int L = $clog2(N);
   localparam logic [1:0] OP_NAND = 2'b11;

   // NAND reduces as AND inside the tree; inversion happens only at the output
   function automatic logic combine(input logic [1:0] o, input logic a, input logic b);
      case (o)
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return a & b;
      endcase
   endfunction

   logic [L-1:0]      valid_q, valid_d;
   logic [L-1:0][1:0] op_q, op_d;
   logic [N-2:0]      part_q, part_d;

   logic [L-1:0]      ready_c;
   logic [L-1:0]      up_vld;
   logic [L-1:0][1:0] up_op;
   logic [N-2:0]      node_c;
   logic [N-2:0]      ld_mask;
   logic [2*N-2:0]    tree_bits;
   logic [1:0]        in_op;

   // Input bits followed by every stored level, so each level has a fixed source offset
   assign tree_bits = {part_q, in_data};

`ifdef REDUCE_ACCUM_EN
   logic [L-1:0] last_q, last_d;
   logic [L-1:0] up_last;
   logic         first_q, first_d;
   logic [1:0]   lock_op_q, lock_op_d;
   logic         acc_q, acc_d;
   logic         acc_has_q, acc_has_d;
`else
   logic         unused_in_last;
   assign unused_in_last = in_last;
`endif

   for (genvar j = 0; j < L; j++) begin : g_stage
      localparam int W   = N >> (j + 1);
      localparam int OFF = N - (N >> j);
      localparam int SRC = 2 * N - 2 * (N >> j);
      if (j == 0) begin : g_head
         assign up_vld[j] = in_valid;
         assign up_op[j]  = in_op;
`ifdef REDUCE_ACCUM_EN
         assign up_last[j] = in_last;
`endif
      end else begin : g_body
         assign up_vld[j] = valid_q[j-1];
         assign up_op[j]  = op_q[j-1];
`ifdef REDUCE_ACCUM_EN
         assign up_last[j] = last_q[j-1];
`endif
      end
      for (genvar i = 0; i < W; i++) begin : g_node
         assign node_c[OFF+i]  = combine(up_op[j], tree_bits[SRC+2*i], tree_bits[SRC+2*i+1]);
         assign ld_mask[OFF+i] = ready_c[j];
      end
   end

   // Ready chain in closed form: a stage can load if out_ready or any stage at/after it is empty
   always_comb begin : p_ready
      logic full;
      full = 1'b1;
      ready_c = '0;
      for (int j = L - 1; j >= 0; j--) begin
         full       = full & valid_q[j];
         ready_c[j] = out_ready | ~full;
      end
      in_ready = ready_c[0];
   end

   // Next-state: every ready stage loads from upstream, stalled stages hold
   always_comb begin
      part_d = (node_c & ld_mask) | (part_q & ~ld_mask);
      for (int j = 0; j < L; j++) begin
         valid_d[j] = ready_c[j] ? up_vld[j] : valid_q[j];
         op_d[j]    = ready_c[j] ? up_op[j]  : op_q[j];
      end
`ifdef REDUCE_ACCUM_EN
      // The op of the first beat in a burst is locked for the rest of that burst
      in_op     = first_q ? op : lock_op_q;
      first_d   = first_q;
      lock_op_d = lock_op_q;
      if (in_valid && in_ready) begin
         first_d = in_last;
         if (first_q) lock_op_d = op;
      end
      for (int j = 0; j < L; j++) begin
         last_d[j] = ready_c[j] ? up_last[j] : last_q[j];
      end
      // Last stage folds tree results; only the closing beat becomes visible
      acc_d     = acc_q;
      acc_has_d = acc_has_q;
      valid_d[L-1] = ready_c[L-1] ? (up_vld[L-1] & up_last[L-1]) : valid_q[L-1];
      if (ready_c[L-1] && up_vld[L-1]) begin
         if (up_last[L-1]) begin
            part_d[N-2] = acc_has_q ? combine(up_op[L-1], acc_q, node_c[N-2]) : node_c[N-2];
            acc_d       = 1'b0;
            acc_has_d   = 1'b0;
         end else begin
            acc_d       = acc_has_q ? combine(up_op[L-1], acc_q, node_c[N-2]) : node_c[N-2];
            acc_has_d   = 1'b1;
            part_d[N-2] = part_q[N-2];
         end
      end
`else
      in_op = op;
`endif
   end

   // State registers; reset drops every in-flight beat and any partial burst
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         op_q    <= '0;
         part_q  <= '0;
`ifdef REDUCE_ACCUM_EN
         last_q    <= '0;
         first_q   <= 1'b1;
         lock_op_q <= '0;
         acc_q     <= 1'b0;
         acc_has_q <= 1'b0;
`endif
      end else begin
         valid_q <= valid_d;
         op_q    <= op_d;
         part_q  <= part_d;
`ifdef REDUCE_ACCUM_EN
         last_q    <= last_d;
         first_q   <= first_d;
         lock_op_q <= lock_op_d;
         acc_q     <= acc_d;
         acc_has_q <= acc_has_d;
`endif
      end
   end

   // Output view of the last stage; NAND inversion applied here only
   always_comb begin
      out_valid = valid_q[L-1];
      out       = tree_bits[2*N-2] ^ (op_q[L-1] == OP_NAND);
`ifdef REDUCE_ACCUM_EN
      out_last  = valid_q[L-1] & last_q[L-1];
`else
      out_last  = valid_q[L-1];
`endif
   end

endmodule
